// File: rtl/serial_add_defs_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and default width.
package serial_add_defs;

    localparam int unsigned WIDTH_DEF = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/serial_fa_cell.sv
// Single-bit full adder used as the datapath of the serial adder.
module serial_fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: feeds one full-adder cell LSB-first, one bit per clock.
// Optional subtract mode is enabled with the SERIAL_ADD_SUB_EN macro (adds port sub).
module serial_add_ctrl
    import serial_add_defs::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               cell_s, cell_co;
    logic               last_bit;
    logic [WIDTH-1:0]   b_load;
    logic               carry_load;

    serial_fa_cell u_cell (
        .x  (a_sr_q[0]),
        .y  (b_sr_q[0]),
        .ci (carry_q),
        .s  (cell_s),
        .co (cell_co)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Subtraction is a + ~b + 1, so only the loaded B and carry differ.
`ifdef SERIAL_ADD_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)    state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE:               state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b_load;
                    carry_d  = carry_load;
                    cnt_d    = '0;
                    sum_sr_d = '0;
                end
            end
            ST_RUN: begin
                sum_sr_d = {cell_s, sum_sr_q[WIDTH-1:1]};
                carry_d  = cell_co;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // Result registers load only on entry to DONE and hold otherwise.
                if (last_bit) begin
                    sum_d  = {cell_s, sum_sr_q[WIDTH-1:1]};
                    cout_d = cell_co;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8); subtract vectors run when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic         sub   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] last_sum = '0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands with a one-cycle start; returns at the first sample after the accepting edge.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic sv);
        @(negedge clk);
        a = av; b = bv; cin = cv; sub = sv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    endtask

    // Bounded wait for done; lat counts samples since the accepting edge (1 = first).
    task automatic wait_done(input logic [W-1:0] hold, output int lat,
                             output int busy_cnt, output bit hold_ok);
        lat = 1; busy_cnt = 0; hold_ok = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (sum !== hold) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy === 1'b1) busy_cnt++;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic sv,
                          input logic [W-1:0] es, input logic ec);
        int lat, bc;
        bit hold_ok;
        launch(av, bv, cv, sv);
        wait_done(last_sum, lat, bc, hold_ok);
        chk({tag, ".latency"}, 32'(lat), 32'd9);
        chk({tag, ".busy_cycles"}, 32'(bc), 32'd9);
        chk({tag, ".sum"}, 32'(sum), 32'(es));
        chk({tag, ".cout"}, 32'(cout), 32'(ec));
        chk({tag, ".hold_prev"}, 32'(hold_ok), 32'd1);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
        chk({tag, ".idle"}, 32'(busy), 32'd0);
        chk({tag, ".sum_held"}, 32'(sum), 32'(es));
        last_sum = es;
    endtask

    initial begin
        int lat, bc;
        bit hold_ok, saw_done;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   ref_v;

        #2;
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.sum",  32'(sum),  32'd0);
        chk("reset.cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

        // Starts during RUN and DONE are ignored; a held start fires from the next IDLE cycle.
        launch(8'h21, 8'h13, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'hAA; b = 8'hAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(last_sum, lat, bc, hold_ok);
        chk("ignore.done_seen", 32'(done), 32'd1);
        chk("ignore.sum", 32'(sum), 32'h34);
        chk("ignore.cout", 32'(cout), 32'd0);
        a = 8'h0F; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        chk("ignore.done_cycle_start", 32'(busy), 32'd0);
        last_sum = 8'h34;
        @(negedge clk);
        start = 1'b0;
        chk("retrigger.busy", 32'(busy), 32'd1);
        wait_done(last_sum, lat, bc, hold_ok);
        chk("retrigger.latency", 32'(lat), 32'd9);
        chk("retrigger.sum", 32'(sum), 32'h10);
        chk("retrigger.cout", 32'(cout), 32'd0);
        chk("retrigger.hold_prev", 32'(hold_ok), 32'd1);
        last_sum = 8'h10;
        @(negedge clk);

        // Asynchronous abort after three bits have been processed.
        launch(8'h55, 8'h0F, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.sum",  32'(sum),  32'd0);
        chk("abort.cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        chk("abort.no_activity", 32'(saw_done), 32'd0);
        last_sum = '0;
        run_op("post_abort", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        run_op("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0);
        run_op("sub_then_add", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);
`endif

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            ref_v = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
            run_op("random", ra, rb, rc, 1'b0, ref_v[W-1:0], ref_v[W]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
